// File: rtl/mem_ws_if.sv
// Bus bundle for the wait-state memory: active-low chip select, read/write
// strobes, byte enables, word address and the active-low completion strobe.
// The bidirectional data bus is a module-level inout so the tri-state
// resolution stays on a single plain net.
//
// Handshake: a request is presented by holding CS_=0 with exactly one of
// RD_/WR_ low; the memory answers with RDY_=0 for exactly one cycle once the
// access is done, and will not start another access until the requester has
// released CS_ or both strobes.
interface mem_ws_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic            CS_;
    logic            RD_;
    logic            WR_;
    logic [DW/8-1:0] BE_;
    logic [AW-1:0]   Addr;
    logic            RDY_;

    modport master (output CS_, RD_, WR_, BE_, Addr, input RDY_);
    modport slave  (input CS_, RD_, WR_, BE_, Addr, output RDY_);
endinterface

// File: rtl/mem_ws.sv
// Single-port synchronous memory with programmable wait states, byte write
// enables, active-low strobes and a one-cycle active-low ready pulse.
// A small controller (IDLE/BUSY/ACK/REL) latches the request, counts out the
// wait states, performs the access once and then waits for the strobes to be
// released so a held strobe never triggers a second access.
module mem_ws #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int DEPTH = 1 << AW,
    parameter int WAIT  = 2
) (
    input  logic          Clk,
    input  logic          Rst_,
    mem_ws_if.slave       bus,
    inout  wire [DW-1:0]  Data,
    output logic [1:0]    dbg_state,
    output logic          dbg_drive
);

    localparam int NB = DW / 8;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q;
    logic            rd_q;
    logic [NB-1:0]   be_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;

    logic            req;
    logic            abort;
    logic            take_req;
    logic            do_access;
    logic            in_range;
    logic            drive;

    logic [DW-1:0]   mem [0:DEPTH-1];

    // A legal request: selected, and exactly one strobe low.
    assign req = !bus.CS_ && (bus.RD_ != bus.WR_);

    // Deselect or release of the strobe that started the access cancels it.
    assign abort = bus.CS_ || (rd_q ? bus.RD_ : bus.WR_);

    // Addresses beyond DEPTH complete the handshake but touch no storage.
    assign in_range = ({1'b0, addr_q} < DEPTH_V);

    // State and wait counter register.
    always_ff @(posedge Clk or negedge Rst_) begin
        if (!Rst_) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: request capture, wait countdown, one-shot access.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take_req  = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    take_req = 1'b1;
                    cnt_d    = WAIT_CNT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                state_d = REL;
            end
            REL: begin
                if (bus.CS_ || (bus.RD_ && bus.WR_)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture address, operation, byte enables and write data at the request edge.
    always_ff @(posedge Clk or negedge Rst_) begin
        if (!Rst_) begin
            addr_q  <= '0;
            rd_q    <= 1'b0;
            be_q    <= '1;
            wdata_q <= '0;
        end else if (take_req) begin
            addr_q <= bus.Addr;
            rd_q   <= !bus.RD_;
            be_q   <= bus.BE_;
            if (bus.RD_) begin
                wdata_q <= Data;
            end
        end
    end

    // Read result register; out-of-range reads return zero.
    always_ff @(posedge Clk or negedge Rst_) begin
        if (!Rst_) begin
            rdata_q <= '0;
        end else if (do_access && rd_q) begin
            rdata_q <= in_range ? mem[addr_q] : '0;
        end
    end

    // Storage write with per-byte enables; contents survive reset.
    always_ff @(posedge Clk) begin
        if (do_access && !rd_q && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (!be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Drive the bus only with read data, only after the access, and only
    // while the requester still selects the memory with RD_ low.
    assign drive    = rd_q && ((state_q == ACK) || (state_q == REL)) && !bus.CS_ && !bus.RD_;
    assign Data     = drive ? rdata_q : {DW{1'bz}};
    assign bus.RDY_ = (state_q != ACK);

    assign dbg_state = state_q;
    assign dbg_drive = drive;

endmodule

// File: doc/mem_ws.md
# mem_ws

Parametrised single-port synchronous memory with programmable wait states, byte write enables and an active-low ready handshake. It keeps the bidirectional tri-state data bus and active-low CS_/RD_/WR_ strobes of our test memories. It adds a controller FSM so CPU bus interface logic can be exercised against slow memory. It is instantiated in the processor testbench as instruction or data memory and is preloaded with $readmemh by the bench.

## Interface
- DW, 32: data width in bits; multiple of 8.
- AW, 10: address width.
- DEPTH, 1<<AW: number of words; must be ≤ 2^AW.
- WAIT, 2: wait states inserted per access, 0..15.
- Clk  in  1  rising-edge clock.
- Rst_  in  1  reset, asynchronous, active-low.
- CS_  in  1  chip select, active-low.
- RD_  in  1  read strobe, active-low.
- WR_  in  1  write strobe, active-low.
- BE_  in  DW/8  byte enables for writes, active-low; bit i covers Data[8i+7:8i].
- Addr  in  AW  word address.
- Data  inout  DW  bidirectional data; Hi-Z when not driven.
- RDY_  out  1  access-complete strobe, active-low, one cycle wide.

## Operation
- States: IDLE, BUSY, ACK, REL.
- IDLE: at a rising edge, a request is CS_=0 with exactly one of RD_/WR_ at 0. On a request:
  - Latch Addr, op, BE_ and (for writes) Data.
  - Load cnt=WAIT and go to BUSY.
- IDLE, RD_=0 and WR_=0 together: illegal; ignored, state stays IDLE.
- BUSY: each edge with cnt≠0 decrements cnt. The edge with cnt=0 goes to ACK and performs the access from the latched values:
  - Write: update only the bytes whose BE_ bit is 0.
  - Read: register mem[addr] into rdata_q.
- BUSY abort: if CS_=1, or the latched strobe deasserts, at any BUSY edge, go to IDLE. Nothing is written and RDY_ is never asserted.
- ACK: lasts one cycle with RDY_=0, then go to REL.
- REL: wait until CS_=1 or RD_=WR_=1, then go to IDLE. A held strobe never produces a second access.
- Data drive (combinational): Data = rdata_q when latched op=read, state ∈ {ACK, REL}, CS_=0 and RD_=0; otherwise Hi-Z. The memory never drives Data during BUSY.
- Out of range (Addr ≥ DEPTH): writes are dropped; reads return 0. The handshake completes normally.
- Addr, Data and BE_ changes after the request edge are ignored.

## Timing
- Request sampled at edge 0. Access and state transition to ACK happen at edge 1+WAIT. RDY_ is low from edge 1+WAIT to edge 2+WAIT.
- WAIT=0 gives RDY_ one cycle after the request edge.
- Read data is valid on Data from edge 1+WAIT for as long as CS_=0 and RD_=0.
- Write data is visible to a read whose access edge comes after the commit edge.
- Minimum access-to-access spacing: ACK, one REL cycle with strobes released, then IDLE samples the next request.
- Reset (Rst_=0, asynchronous):
  - State IDLE, cnt=0, rdata_q=0, RDY_=1, Data Hi-Z.
  - Memory contents are not cleared.
  - Reset before the commit edge leaves memory unchanged.
- Release of Rst_ is synchronised by the bench. The first request is sampled no earlier than the first edge after release.

## Test plan
- Reset: assert Rst_=0 mid-BUSY of a write of 0x12345678 to 0x004 → RDY_=1 and Data=Z immediately; mem[0x004] unchanged.
- Write then read, WAIT=2: write 0xDEADBEEF to 0x005 with BE_=0000 → RDY_ low exactly 3 edges after the request edge. Read 0x005 → Data=0xDEADBEEF after 3 edges, Z when RD_ rises.
- Byte enables: write 0x11223344 with BE_=1010 to 0x005 (holding 0xDEADBEEF) → readback 0xDE22BE44.
- Abort: start a write of 0xCAFEF00D to 0x010, raise CS_ in the second BUSY cycle → no RDY_; mem[0x010] keeps its preloaded value.
- Held strobe: keep CS_=RD_=0 for 10 cycles after RDY_ on a read → exactly one RDY_ pulse; Data stays driven until release. The next request after release gets a fresh RDY_.
- Parameter sweep: WAIT=0 and WAIT=15, DW=64 with DEPTH=600 and AW=10. Check the following:
  - RDY_ latency is 1+WAIT.
  - A read of 0x3FF returns 0.
  - A write to 0x3FF is dropped.
  - An illegal RD_=WR_=0 request gives no RDY_.
